// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle for one requester port of the
// data-memory arbiter (core load/store path or host loader port).
//   req    master->slave  access request, held until gnt
//   we     master->slave  1=write, 0=read
//   addr   master->slave  byte address
//   wdata  master->slave  write data
//   gnt    slave->master  access performed this cycle (combinational)
//   rvalid slave->master  read data valid, cycle after a read grant
//   rdata  slave->master  read data, 0 while rvalid=0
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port byte-wide synchronous data memory between
// the core load/store port and the host port. One access per cycle,
// round-robin on conflict; the host may lock the memory for bursts of at most
// LOCK_MAX cycles, after which the core gets one guaranteed slot.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   core, host            requester ports (dmem_arbiter_if.slave)
//   host_lock             host requests/keeps exclusive ownership
//   mem_en/we/addr/wdata  memory strobe and muxed winner command (0 when idle)
//   mem_rdata             memory read data, valid cycle after a read strobe
//   core_stall_cnt        (only with DMEM_ARB_STATS_EN) saturating count of
//                         cycles the core requested without a grant
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave core,
  dmem_arbiter_if.slave host,
  input  logic          host_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   core_stall_cnt
`endif
);
  localparam int   CW   = $clog2(LOCK_MAX + 1);
  localparam logic CORE = 1'b0;
  localparam logic HOST = 1'b1;

  typedef enum logic [1:0] {ARB, LOCKED, YIELD} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;   // port granted most recently
  logic [CW-1:0] cnt_q, cnt_d;     // host-owned cycles in current burst
  logic [1:0]    rd_q;             // read owner tag, one bit per port
  logic [1:0]    req, gnt;

  assign req = {host.req, core.req};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= HOST;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rd_q    <= gnt & {2{~mem_we}};
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (|gnt) last_d = gnt[HOST];
    case (state_q)
      ARB: if (gnt[HOST] && host_lock) begin
        state_d = LOCKED;
        cnt_d   = CW'(1);
      end
      LOCKED: begin
        cnt_d = cnt_q + 1'b1;
        if (!host_lock) begin
          state_d = ARB;
          last_d  = HOST;
        end else if (cnt_d == CW'(LOCK_MAX)) begin
          // burst has used its full budget: give the core one slot
          state_d = YIELD;
        end
      end
      YIELD:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grants; forced to 0 during reset so every output is quiet that cycle
  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state_q)
        ARB: begin
          if (&req) gnt[~last_q] = 1'b1;
          else      gnt = req;
        end
        LOCKED: gnt[HOST] = req[HOST];
        YIELD: begin
          gnt[CORE] = req[CORE];
          gnt[HOST] = req[HOST] & ~req[CORE];
        end
        default: gnt = '0;
      endcase
    end
  end

  assign core.gnt = gnt[CORE];
  assign host.gnt = gnt[HOST];
  assign mem_en   = |gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[CORE]) begin
      mem_we    = core.we;
      mem_addr  = core.addr;
      mem_wdata = core.wdata;
    end else if (gnt[HOST]) begin
      mem_we    = host.we;
      mem_addr  = host.addr;
      mem_wdata = host.wdata;
    end
  end

  // A read granted just before reset must not surface during reset
  assign core.rvalid = rd_q[CORE] & ~reset;
  assign host.rvalid = rd_q[HOST] & ~reset;
  assign core.rdata  = core.rvalid ? mem_rdata : '0;
  assign host.rdata  = host.rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (req[CORE] && !gnt[CORE] && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign core_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// synchronous 256x8 memory. Preload goes through the host port.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) core_if ();
  dmem_arbiter_if #(.AW(8), .DW(8)) host_if ();

  logic       host_lock, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] core_stall_cnt;
`endif

  dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (core_if),
    .host      (host_if),
    .host_lock (host_lock),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .core_stall_cnt (core_stall_cnt)
`endif
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic core_drv(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    core_if.req = r; core_if.we = w; core_if.addr = a; core_if.wdata = d;
  endtask

  task automatic host_drv(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic l);
    host_if.req = r; host_if.we = w; host_if.addr = a; host_if.wdata = d; host_lock = l;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_drv(1, 1, a, d, 0);
    @(negedge clk);
    chk("preload_gnt", host_if.gnt, 1);
    tick;
    host_drv(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with every request asserted: all outputs must stay quiet
    reset = 1'b1;
    core_drv(1, 1, 8'h33, 8'h77);
    host_drv(1, 1, 8'h44, 8'h88, 1);
    tick;
    @(negedge clk);
    chk("rst_core_gnt", core_if.gnt, 0);
    chk("rst_host_gnt", host_if.gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_rvalid", core_if.rvalid, 0);
    chk("rst_host_rvalid", host_if.rvalid, 0);
    do_reset;

    host_write(8'h40, 8'hA5);
    host_write(8'h10, 8'h01);
    host_write(8'h20, 8'h02);
    tick;

    // 1. core-only read
    core_drv(1, 0, 8'h40, 0);
    @(negedge clk);
    chk("t1_core_gnt", core_if.gnt, 1);
    chk("t1_host_gnt", host_if.gnt, 0);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 8'h40);
    tick;
    core_drv(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_core_rvalid", core_if.rvalid, 1);
    chk("t1_core_rdata", core_if.rdata, 8'hA5);
    chk("t1_host_rvalid", host_if.rvalid, 0);
    chk("t1_idle_en", mem_en, 0);
    chk("t1_idle_addr", mem_addr, 0);
    tick;

    // 2. round-robin under sustained conflict
    do_reset;
    core_drv(1, 0, 8'h10, 0);
    host_drv(1, 0, 8'h20, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_core_gnt", core_if.gnt, (i % 2) == 0);
      chk("t2_host_gnt", host_if.gnt, (i % 2) == 1);
      if (i > 0) begin
        chk("t2_core_rvalid", core_if.rvalid, (i % 2) == 1);
        chk("t2_host_rvalid", host_if.rvalid, (i % 2) == 0);
        chk("t2_rdata", (i % 2) ? core_if.rdata : host_if.rdata, (i % 2) ? 8'h01 : 8'h02);
      end
      tick;
    end
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_last_host_rvalid", host_if.rvalid, 1);
    chk("t2_last_host_rdata", host_if.rdata, 8'h02);
    chk("t2_last_core_rvalid", core_if.rvalid, 0);
    tick;

    // 3. locked host write burst with the core waiting
    for (int i = 0; i < 4; i++) begin
      host_drv(1, 1, 8'(i), 8'(8'h11 * (i + 1)), 1);
      if (i > 0) core_drv(1, 0, 8'h50, 0);
      @(negedge clk);
      chk("t3_host_gnt", host_if.gnt, 1);
      chk("t3_core_gnt", core_if.gnt, 0);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, i);
      chk("t3_mem_wdata", mem_wdata, 8'(8'h11 * (i + 1)));
      tick;
    end
    host_drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_drop_core_gnt", core_if.gnt, 0);
    chk("t3_drop_host_gnt", host_if.gnt, 0);
    tick;
    @(negedge clk);
    chk("t3_core_after_unlock", core_if.gnt, 1);
    tick;
    core_drv(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      host_drv(1, 0, 8'(i), 0, 0);
      @(negedge clk);
      chk("t3_rb_gnt", host_if.gnt, 1);
      if (i == 0) chk("t3_core_rvalid", core_if.rvalid, 1);
      else begin
        chk("t3_rb_rvalid", host_if.rvalid, 1);
        chk("t3_rb_rdata", host_if.rdata, 8'(8'h11 * i));
      end
      tick;
    end
    host_drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_rb_rvalid", host_if.rvalid, 1);
    chk("t3_rb_rdata", host_if.rdata, 8'h44);
    tick;

    // 4. lock budget: 16 host grants, one core slot, then host relocks
    do_reset;
    host_drv(1, 0, 8'h40, 0, 1);
    for (int c = 0; c < 20; c++) begin
      if (c == 1) core_drv(1, 0, 8'h40, 0);
      @(negedge clk);
      chk("t4_core_gnt", core_if.gnt, c == 16);
      chk("t4_host_gnt", host_if.gnt, c != 16);
      tick;
    end
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick;

    // 5. reset the cycle after a granted host read
    do_reset;
    host_drv(1, 0, 8'h40, 0, 0);
    @(negedge clk);
    chk("t5_host_gnt", host_if.gnt, 1);
    tick;
    reset = 1'b1;
    core_drv(1, 0, 8'h10, 0);
    @(negedge clk);
    chk("t5_host_rvalid", host_if.rvalid, 0);
    chk("t5_host_rdata", host_if.rdata, 0);
    chk("t5_host_gnt_rst", host_if.gnt, 0);
    chk("t5_core_gnt_rst", core_if.gnt, 0);
    chk("t5_mem_en_rst", mem_en, 0);
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_conflict_core", core_if.gnt, 1);
    chk("t5_conflict_host", host_if.gnt, 0);
    chk("t5_no_stale_rvalid", host_if.rvalid, 0);
    tick;
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick;

    // 5b. core won last before reset; core must still win the next conflict
    core_drv(1, 0, 8'h10, 0);
    tick;
    reset = 1'b1;
    core_drv(0, 0, 0, 0);
    tick;
    reset = 1'b0;
    core_drv(1, 0, 8'h10, 0);
    host_drv(1, 0, 8'h20, 0, 0);
    @(negedge clk);
    chk("t5b_core_gnt", core_if.gnt, 1);
    chk("t5b_host_gnt", host_if.gnt, 0);
    tick;
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick;

`ifdef DMEM_ARB_STATS_EN
    // 6. stall counter: 5 blocked cycles, then saturation
    do_reset;
    host_drv(1, 0, 8'h40, 0, 1);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) core_drv(1, 0, 8'h40, 0);
      tick;
    end
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick;
    @(negedge clk);
    chk("t6_stall_5", core_stall_cnt, 16'd5);
    dut.stall_q = 16'hFFFD;
    tick;
    host_drv(1, 0, 8'h40, 0, 1);
    tick;
    core_drv(1, 0, 8'h40, 0);
    for (int c = 0; c < 3; c++) tick;
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0, 0);
    tick;
    @(negedge clk);
    chk("t6_stall_sat", core_stall_cnt, 16'hFFFF);
    tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
